// File: rtl/pkt_stream_player.sv
// Packet replay engine: preloaded flit memory + descriptor table replayed as header beat + AXI-Stream payload.
// Define REPLAY_LOOP_EN for continuous looping replay that ends at a packet boundary after stop.
module pkt_stream_player #(
  parameter int DATA_WIDTH = 64,
  parameter int FLIT_DEPTH = 256,
  parameter int MAX_PKTS   = 16,
  parameter int HDR_WIDTH  = 256,
  localparam int FA = $clog2(FLIT_DEPTH),
  localparam int PA = $clog2(MAX_PKTS),
  localparam int KW = DATA_WIDTH/8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  ld_flit_we,
  input  logic [FA-1:0]         ld_flit_addr,
  input  logic [DATA_WIDTH-1:0] ld_flit_data,
  input  logic [KW-1:0]         ld_flit_keep,
  input  logic                  ld_desc_we,
  input  logic [PA-1:0]         ld_desc_idx,
  input  logic [7:0]            ld_desc_type,
  input  logic [FA-1:0]         ld_desc_start,
  input  logic [FA:0]           ld_desc_end,
  input  logic [HDR_WIDTH-1:0]  ld_desc_hdr,
  input  logic [PA:0]           num_pkts,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [7:0]            hdr_type,
  output logic [HDR_WIDTH-1:0]  hdr_data,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KW-1:0]         m_tkeep,
  output logic                  m_tlast
);

  typedef enum logic [2:0] {S_IDLE, S_DESC, S_HDR, S_DATA, S_NEXT, S_FIN} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] flit_mem [FLIT_DEPTH];
  logic [KW-1:0]         keep_mem [FLIT_DEPTH];
  logic [7:0]            desc_type  [MAX_PKTS];
  logic [FA-1:0]         desc_start [MAX_PKTS];
  logic [FA:0]           desc_end   [MAX_PKTS];
  logic [HDR_WIDTH-1:0]  desc_hdr   [MAX_PKTS];

  logic [PA-1:0]         idx;
  logic [PA:0]           idx_nxt, num_q;
  logic [FA-1:0]         rd_addr;
  logic [FA:0]           rd_left;
  logic                  rd_en, rd_vld, rd_last;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [KW-1:0]         rd_keep;
  logic                  skid_vld, skid_last;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [KW-1:0]         skid_keep;
  logic [1:0]            occ;
  logic                  room, data_done;

  // Flits in flight (read stage + output + skid) never exceed two after an issue, so the skid never overflows.
  assign occ       = 2'(rd_vld) + 2'(m_tvalid) + 2'(skid_vld);
  assign room      = (m_tvalid && m_tready) ? (occ <= 2'd2) : (occ <= 2'd1);
  assign rd_en     = (rd_left != '0) && room &&
                     ((state == S_DATA) || (state == S_HDR && hdr_ready));
  assign data_done = (rd_left == '0) && !rd_vld && !skid_vld && (!m_tvalid || m_tready);
  assign idx_nxt   = {1'b0, idx} + (PA+1)'(1);

  always_ff @(posedge aclk) begin
    if (ld_flit_we && !busy) begin
      flit_mem[ld_flit_addr] <= ld_flit_data;
      keep_mem[ld_flit_addr] <= ld_flit_keep;
    end
    if (ld_desc_we && !busy) begin
      desc_type[ld_desc_idx]  <= ld_desc_type;
      desc_start[ld_desc_idx] <= ld_desc_start;
      desc_end[ld_desc_idx]   <= ld_desc_end;
      desc_hdr[ld_desc_idx]   <= ld_desc_hdr;
    end
    if (rd_en) begin
      rd_data <= flit_mem[rd_addr];
      rd_keep <= keep_mem[rd_addr];
    end
  end

`ifdef REPLAY_LOOP_EN
  logic stop_req;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                  stop_req <= 1'b0;
    else if (state == S_IDLE)      stop_req <= 1'b0;
    else if (stop)                 stop_req <= 1'b1;
  end
`else
  logic unused_stop;
  assign unused_stop = stop;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      num_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_type  <= '0;
      hdr_data  <= '0;
      rd_addr   <= '0;
      rd_left   <= '0;
    end else begin
      if (rd_en) begin
        rd_addr <= rd_addr + FA'(1);
        rd_left <= rd_left - (FA+1)'(1);
      end
      case (state)
        S_IDLE: if (start) begin
          busy  <= 1'b1;
          done  <= 1'b0;
          idx   <= '0;
          num_q <= (num_pkts > (PA+1)'(MAX_PKTS)) ? (PA+1)'(MAX_PKTS) : num_pkts;
          state <= (num_pkts == '0) ? S_FIN : S_DESC;
        end
        S_DESC: begin
          hdr_type <= desc_type[idx];
          hdr_data <= desc_hdr[idx];
          rd_addr  <= desc_start[idx];
          rd_left  <= desc_end[idx] - {1'b0, desc_start[idx]};
          if (desc_type[idx] != 8'd0) begin
            hdr_valid <= 1'b1;
            state     <= S_HDR;
          end else begin
            state     <= S_DATA;
          end
        end
        S_HDR: if (hdr_ready) begin
          hdr_valid <= 1'b0;
          state     <= S_DATA;
        end
        S_DATA: if (data_done) state <= S_NEXT;
        S_NEXT: begin
          if (idx_nxt < num_q) begin
            idx   <= idx_nxt[PA-1:0];
            state <= S_DESC;
          end else begin
`ifdef REPLAY_LOOP_EN
            if (stop_req || stop) begin
              state <= S_FIN;
            end else begin
              idx   <= '0;
              state <= S_DESC;
            end
`else
            state <= S_FIN;
`endif
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register plus one skid entry; the head only advances on accept, so AXIS data holds while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tlast   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_keep <= '0;
      skid_last <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) rd_last <= (rd_left == (FA+1)'(1));
      if (!m_tvalid || m_tready) begin
        if (skid_vld) begin
          m_tvalid <= 1'b1;
          m_tdata  <= skid_data;
          m_tkeep  <= skid_keep;
          m_tlast  <= skid_last;
          skid_vld <= rd_vld;
          if (rd_vld) begin
            skid_data <= rd_data;
            skid_keep <= rd_keep;
            skid_last <= rd_last;
          end
        end else begin
          m_tvalid <= rd_vld;
          if (rd_vld) begin
            m_tdata <= rd_data;
            m_tkeep <= rd_keep;
            m_tlast <= rd_last;
          end
        end
      end else if (rd_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= rd_data;
        skid_keep <= rd_keep;
        skid_last <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_pkt_stream_player.sv
// Directed scoreboard bench for pkt_stream_player: expected headers/flits queued at stimulus, checked by a monitor.
module tb_pkt_stream_player;
  localparam int DW = 64, FD = 256, MP = 16, HW = 256;
  localparam int FA = 8, PA = 4, KW = 8;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic ld_flit_we = 0, ld_desc_we = 0, start = 0, stop = 0, hdr_ready = 0, m_tready = 0;
  logic [FA-1:0] ld_flit_addr = '0, ld_desc_start = '0;
  logic [DW-1:0] ld_flit_data = '0;
  logic [KW-1:0] ld_flit_keep = '0;
  logic [PA-1:0] ld_desc_idx = '0;
  logic [7:0]    ld_desc_type = '0;
  logic [FA:0]   ld_desc_end = '0;
  logic [HW-1:0] ld_desc_hdr = '0;
  logic [PA:0]   num_pkts = '0;
  logic busy, done, hdr_valid, m_tvalid, m_tlast;
  logic [7:0] hdr_type;
  logic [HW-1:0] hdr_data;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;

  pkt_stream_player #(.DATA_WIDTH(DW), .FLIT_DEPTH(FD), .MAX_PKTS(MP), .HDR_WIDTH(HW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ld_flit_we(ld_flit_we), .ld_flit_addr(ld_flit_addr), .ld_flit_data(ld_flit_data), .ld_flit_keep(ld_flit_keep),
    .ld_desc_we(ld_desc_we), .ld_desc_idx(ld_desc_idx), .ld_desc_type(ld_desc_type),
    .ld_desc_start(ld_desc_start), .ld_desc_end(ld_desc_end), .ld_desc_hdr(ld_desc_hdr),
    .num_pkts(num_pkts), .start(start), .stop(stop), .busy(busy), .done(done),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_type(hdr_type), .hdr_data(hdr_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast));

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } flit_t;
  typedef struct { logic [7:0] t; logic [HW-1:0] h; } hdr_t;
  flit_t fq[$];
  hdr_t  hq[$];
  int n_cmp = 0, n_bad = 0, pkt_seen = 0;

  task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fv(input int a);
    return {32'hCAFE0000 | 32'(a), 32'h12340000 + 32'(a * 3)};
  endfunction

  // Monitor: the front of each queue must be presented while valid (covers stall stability) and pops on accept.
  always @(negedge aclk) if (aresetn) begin
    if (hdr_valid) begin
      if (hq.size() == 0) chk("hdr_unexpected", 1, 0);
      else begin
        chk("hdr_type", hdr_type, hq[0].t);
        chk("hdr_data", hdr_data, hq[0].h);
        if (hdr_ready) void'(hq.pop_front());
      end
    end
    if (m_tvalid) begin
      if (fq.size() == 0) chk("flit_unexpected", 1, 0);
      else begin
        chk("tdata", m_tdata, fq[0].d);
        chk("tkeep", m_tkeep, fq[0].k);
        chk("tlast", m_tlast, fq[0].l);
        if (m_tready) begin
          if (m_tlast) pkt_seen++;
          void'(fq.pop_front());
        end
      end
    end
  end

  task automatic ld_flit(input int a, input logic [DW-1:0] d, input logic [KW-1:0] k);
    ld_flit_we = 1; ld_flit_addr = FA'(a); ld_flit_data = d; ld_flit_keep = k;
    @(posedge aclk); #1 ld_flit_we = 0;
  endtask

  task automatic ld_desc(input int i, input int t, input int s, input int e, input logic [HW-1:0] h);
    ld_desc_we = 1; ld_desc_idx = PA'(i); ld_desc_type = 8'(t);
    ld_desc_start = FA'(s); ld_desc_end = (FA+1)'(e); ld_desc_hdr = h;
    @(posedge aclk); #1 ld_desc_we = 0;
  endtask

  task automatic push_flit(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    fq.push_back('{d: d, k: k, l: l});
  endtask

  task automatic push_hdr(input int t, input logic [HW-1:0] h);
    hq.push_back('{t: 8'(t), h: h});
  endtask

  task automatic start_pulse();
    start = 1; @(posedge aclk); #1 start = 0;
  endtask

  task automatic wait_done(input int max_cyc, input bit toggle);
    for (int i = 0; i < max_cyc && !done; i++) begin
      if (toggle) m_tready = ~m_tready;
      @(posedge aclk); #1;
    end
    chk("done_reached", done, 1);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_hq_empty"}, HW'(hq.size()), 0);
    chk({nm, "_fq_empty"}, HW'(fq.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_hdr_valid", hdr_valid, 0); chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);     chk("rst_tdata", m_tdata, 0);
    chk("rst_hdr_data", hdr_data, 0); chk("rst_hdr_type", hdr_type, 0);
    aresetn = 1;
    @(posedge aclk); #1;

    // 1: ETH packet, 4 flits, fixed latencies
    for (int a = 0; a < 4; a++) ld_flit(a, fv(a), (a == 3) ? 8'h0F : 8'hFF);
    ld_desc(0, 1, 0, 4, {8{32'hE7E70001}});
    push_hdr(1, {8{32'hE7E70001}});
    for (int a = 0; a < 4; a++) push_flit(fv(a), (a == 3) ? 8'h0F : 8'hFF, a == 3);
    num_pkts = 1; hdr_ready = 1; m_tready = 1;
    start_pulse();
    chk("t1_hdr_valid_early", hdr_valid, 0);
    chk("t1_busy", busy, 1);
    @(posedge aclk); #1 chk("t1_hdr_valid_start+2", hdr_valid, 1);
    @(posedge aclk); #1 chk("t1_tvalid_accept+1", m_tvalid, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge aclk); #1 chk("t1_tvalid_back2back", m_tvalid, 1);
    end
    wait_done(50, 0);
    chk_empty("t1");

    // 2: RAW packet with toggling tready
    for (int a = 8; a < 11; a++) ld_flit(a, fv(a), (a == 10) ? 8'h03 : 8'hFF);
    ld_desc(0, 0, 8, 11, '0);
    for (int a = 8; a < 11; a++) push_flit(fv(a), (a == 10) ? 8'h03 : 8'hFF, a == 10);
    start_pulse();
    wait_done(100, 1);
    m_tready = 1;
    chk_empty("t2");

    // 3: MPI header held off for 10 cycles
    ld_flit(16, fv(16), 8'hFF);
    ld_flit(17, fv(17), 8'h7F);
    ld_desc(0, 2, 16, 18, {4{64'h00D1_5EA5_E000_0002}});
    push_hdr(2, {4{64'h00D1_5EA5_E000_0002}});
    push_flit(fv(16), 8'hFF, 0);
    push_flit(fv(17), 8'h7F, 1);
    hdr_ready = 0;
    start_pulse();
    @(posedge aclk); #1;
    for (int c = 0; c < 10; c++) begin
      chk("t3_hdr_held", hdr_valid, 1);
      chk("t3_no_tvalid", m_tvalid, 0);
      @(posedge aclk); #1;
    end
    hdr_ready = 1;
    wait_done(50, 0);
    chk_empty("t3");

    // 4: packet spanning the flit-memory wrap, addresses 254,255,0,1
    ld_flit(254, fv(254), 8'hFF);
    ld_flit(255, fv(255), 8'hFF);
    ld_flit(0, ~fv(0), 8'hFF);
    ld_flit(1, ~fv(1), 8'h01);
    ld_desc(0, 1, 254, 258, {HW{1'b1}});
    push_hdr(1, {HW{1'b1}});
    push_flit(fv(254), 8'hFF, 0);
    push_flit(fv(255), 8'hFF, 0);
    push_flit(~fv(0), 8'hFF, 0);
    push_flit(~fv(1), 8'h01, 1);
    start_pulse();
    wait_done(50, 0);
    chk_empty("t4");

    // 5: num_pkts == 0
    num_pkts = 0;
    start_pulse();
    chk("t5_done_cleared", done, 0);
    chk("t5_busy", busy, 1);
    @(posedge aclk); #1 chk("t5_done_start+2", done, 1);
    chk("t5_busy_clear", busy, 0);

    // 6: two packets; start and a flit write while busy are ignored
    ld_flit(20, fv(20), 8'hFF);
    ld_flit(21, fv(21), 8'hF0);
    ld_flit(24, fv(24), 8'h01);
    ld_desc(0, 5, 20, 22, {HW/16{16'h5A5A}});
    ld_desc(1, 0, 24, 25, '0);
    push_hdr(5, {HW/16{16'h5A5A}});
    push_flit(fv(20), 8'hFF, 0);
    push_flit(fv(21), 8'hF0, 1);
    push_flit(fv(24), 8'h01, 1);
    num_pkts = 2;
    start_pulse();
    repeat (2) @(posedge aclk);
    #1 start = 1; ld_flit_we = 1; ld_flit_addr = 8'd24; ld_flit_data = 64'hBAD; ld_flit_keep = 8'hFF;
    @(posedge aclk); #1 start = 0; ld_flit_we = 0;
    wait_done(100, 0);
    chk_empty("t6");
    repeat (3) @(posedge aclk); #1 chk("t6_no_restart", busy, 0);

    // 7: reset during a stalled DATA phase
    ld_desc(0, 0, 0, 4, '0);
    push_flit(fv(254) ^ 64'h1, 8'hFF, 0); // dummy front entry, cleared below
    fq.delete();
    push_flit(~fv(0), 8'hFF, 0);
    num_pkts = 1; m_tready = 0;
    start_pulse();
    repeat (4) @(posedge aclk); #1 chk("t7_tvalid_stalled", m_tvalid, 1);
    aresetn = 0; #1;
    chk("t7_busy", busy, 0);         chk("t7_done", done, 0);
    chk("t7_tvalid", m_tvalid, 0);   chk("t7_tdata", m_tdata, 0);
    chk("t7_tkeep", m_tkeep, 0);     chk("t7_tlast", m_tlast, 0);
    chk("t7_hdr_valid", hdr_valid, 0);
    fq.delete();
    @(posedge aclk); #1 aresetn = 1; m_tready = 1;
    repeat (6) @(posedge aclk); #1;
    chk("t7_no_resume_tvalid", m_tvalid, 0);
    chk("t7_no_resume_busy", busy, 0);

`ifdef REPLAY_LOOP_EN
    // 8: loop over 2 packets, stop during the 6th
    ld_desc(0, 1, 30, 32, {HW/8{8'h3C}});
    ld_desc(1, 0, 40, 42, '0);
    for (int a = 30; a < 32; a++) ld_flit(a, fv(a), 8'hFF);
    for (int a = 40; a < 42; a++) ld_flit(a, fv(a), 8'hFF);
    for (int p = 0; p < 6; p++) begin
      if (p % 2 == 0) begin
        push_hdr(1, {HW/8{8'h3C}});
        push_flit(fv(30), 8'hFF, 0); push_flit(fv(31), 8'hFF, 1);
      end else begin
        push_flit(fv(40), 8'hFF, 0); push_flit(fv(41), 8'hFF, 1);
      end
    end
    num_pkts = 2; pkt_seen = 0;
    start_pulse();
    for (int i = 0; i < 200 && pkt_seen < 5; i++) begin @(posedge aclk); #1; end
    chk("t8_five_pkts", HW'(pkt_seen), 5);
    repeat (3) @(posedge aclk);
    #1 stop = 1; @(posedge aclk); #1 stop = 0;
    wait_done(100, 0);
    chk("t8_six_pkts", HW'(pkt_seen), 6);
    chk_empty("t8");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
